// File: rtl/alink_tx_dispatch.sv
// alink_tx_dispatch
// TX-side task dispatcher for the ALINK miner link. It pops fixed-size task
// frames from the TX FIFO, picks an enabled idle channel by round-robin and
// presents each word to the PHY. It also owns the per-channel busy vector.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   txfifo_pop/dout/txcnt    FIFO read strobe, read data (next cycle), word count
//   reg_flush/scan/mask      slave controls: abort, dispatch enable, channel enable
//   done                     per-channel result-received pulse from RX side
//   busy, timeout            per-channel task outstanding / timeout pulse
//   phy_valid/data/chan/last word handshake to PHY, held until phy_ready
//   phy_abort                one-cycle pulse when a partly sent frame is dropped
//   phy_ready                PHY accepts word
//
// Build option: define ALINK_TIMEOUT_EN to enable the per-channel timeout.
// Without it, timeout is tied low and busy clears only on done or mask.
//
// state | meaning
// IDLE  | waiting for scan, a full frame in the FIFO and an eligible channel
// PICK  | latch round-robin channel, clear word counter
// POP   | FIFO read strobe for the next word
// LOAD  | capture FIFO read data into phy_data
// SEND  | present word to PHY until accepted

module alink_tx_dispatch #(
    parameter int TASK_WORDS  = 23,
    parameter int TICK_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        txfifo_pop,
    input  logic [31:0] txfifo_dout,
    input  logic [10:0] txcnt,
    input  logic        reg_flush,
    input  logic        reg_scan,
    input  logic [31:0] reg_mask,
    input  logic [31:0] done,
    output logic [31:0] busy,
    output logic [31:0] timeout,
    output logic        phy_valid,
    output logic [31:0] phy_data,
    output logic [4:0]  phy_chan,
    output logic        phy_last,
    output logic        phy_abort,
    input  logic        phy_ready
);

    if (TASK_WORDS < 2 || TASK_WORDS > 63 || TICK_CYCLES < 1) begin : g_param_check
        $error("alink_tx_dispatch: illegal parameter value");
    end

    localparam logic [10:0] FRAME_WORDS = 11'(TASK_WORDS);
    localparam logic [5:0]  LAST_IDX    = 6'(TASK_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PICK,
        S_POP,
        S_LOAD,
        S_SEND
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  last_ch_q, last_ch_d;
    logic [4:0]  phy_chan_q, phy_chan_d;
    logic [5:0]  word_cnt_q, word_cnt_d;
    logic [31:0] phy_data_q, phy_data_d;
    logic [31:0] busy_q, busy_d;
    logic        phy_abort_q, phy_abort_d;

    logic [31:0] eligible;
    logic [31:0] set_vec;
    logic [31:0] to_clr;
    logic        pick_found;
    logic [4:0]  pick_ch;
    logic [4:0]  idx;

    assign eligible = reg_mask & ~busy_q;

    // Round-robin search starting just above the last served channel;
    // the 5-bit add wraps 31 -> 0, and i == 32 revisits last_ch itself.
    always_comb begin
        pick_found = 1'b0;
        pick_ch    = last_ch_q;
        idx        = '0;
        for (int i = 1; i <= 32; i++) begin
            idx = last_ch_q + 5'(i);
            if (!pick_found && eligible[idx]) begin
                pick_found = 1'b1;
                pick_ch    = idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        last_ch_d   = last_ch_q;
        phy_chan_d  = phy_chan_q;
        word_cnt_d  = word_cnt_q;
        phy_data_d  = phy_data_q;
        phy_abort_d = 1'b0;
        set_vec     = '0;
        case (state_q)
            S_IDLE: begin
                if (reg_scan && !reg_flush && (txcnt >= FRAME_WORDS) && (|eligible))
                    state_d = S_PICK;
            end
            S_PICK: begin
                word_cnt_d = '0;
                if (reg_flush || !pick_found) begin
                    state_d = S_IDLE;
                end else begin
                    last_ch_d  = pick_ch;
                    phy_chan_d = pick_ch;
                    state_d    = S_POP;
                end
            end
            S_POP: begin
                if (reg_flush) begin
                    state_d     = S_IDLE;
                    phy_abort_d = (word_cnt_q != '0);
                    word_cnt_d  = '0;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (reg_flush) begin
                    state_d     = S_IDLE;
                    phy_abort_d = (word_cnt_q != '0);
                    word_cnt_d  = '0;
                end else begin
                    phy_data_d = txfifo_dout;
                    state_d    = S_SEND;
                end
            end
            S_SEND: begin
                // Flush beats a same-cycle accept: the frame is dropped whole.
                if (reg_flush) begin
                    state_d     = S_IDLE;
                    phy_abort_d = 1'b1;
                    word_cnt_d  = '0;
                end else if (phy_ready) begin
                    if (word_cnt_q == LAST_IDX) begin
                        set_vec[phy_chan_q] = 1'b1;
                        word_cnt_d          = '0;
                        state_d             = S_IDLE;
                    end else begin
                        word_cnt_d = word_cnt_q + 6'd1;
                        state_d    = S_POP;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Set wins over any same-cycle clear on the same bit.
    always_comb begin
        busy_d = (busy_q & ~(done | ~reg_mask | to_clr)) | set_vec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_ch_q   <= 5'd31;
            phy_chan_q  <= '0;
            word_cnt_q  <= '0;
            phy_data_q  <= '0;
            busy_q      <= '0;
            phy_abort_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_ch_q   <= last_ch_d;
            phy_chan_q  <= phy_chan_d;
            word_cnt_q  <= word_cnt_d;
            phy_data_q  <= phy_data_d;
            busy_q      <= busy_d;
            phy_abort_q <= phy_abort_d;
        end
    end

`ifdef ALINK_TIMEOUT_EN
    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_CYCLES - 1);

    logic [PW-1:0]      presc_q, presc_d;
    logic [31:0][1:0]   age_q, age_d;
    logic [31:0]        timeout_q, timeout_d;
    logic               tick;

    always_comb begin
        tick    = (presc_q == PRESC_MAX);
        presc_d = tick ? '0 : presc_q + 1'b1;
        age_d   = age_q;
        to_clr  = '0;
        for (int i = 0; i < 32; i++) begin
            if (set_vec[i] || done[i] || !reg_mask[i]) begin
                age_d[i] = 2'd0;
            end else if (tick && busy_q[i]) begin
                if (age_q[i] == 2'd3) begin
                    to_clr[i] = 1'b1;
                    age_d[i]  = 2'd0;
                end else begin
                    age_d[i] = age_q[i] + 2'd1;
                end
            end
        end
        timeout_d = to_clr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q   <= '0;
            age_q     <= '0;
            timeout_q <= '0;
        end else begin
            presc_q   <= presc_d;
            age_q     <= age_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign to_clr  = '0;
    assign timeout = '0;
`endif

    assign txfifo_pop = (state_q == S_POP);
    assign phy_valid  = (state_q == S_SEND);
    assign phy_last   = (state_q == S_SEND) && (word_cnt_q == LAST_IDX);
    assign phy_data   = phy_data_q;
    assign phy_chan   = phy_chan_q;
    assign phy_abort  = phy_abort_q;
    assign busy       = busy_q;

endmodule

// File: doc/alink_tx_dispatch.md
Name: alink_tx_dispatch

Overview:
- TX-side task dispatcher for the ALINK miner link. It sits downstream of the ALINK TX FIFO, which the wishbone slave fills via txfifo_push/txfifo_din.
- Pops fixed-size task frames from the FIFO and chooses an enabled, idle channel by round-robin. Each frame goes out word-parallel to the PHY on that channel.
- Owns the per-channel busy vector that the wishbone slave reads back. It also honours the slave's reg_mask, reg_scan and reg_flush controls.

Parameters:
- TASK_WORDS, 23, 32-bit words per task frame; legal range 2..63.
- TICK_CYCLES, 50000, clk cycles per timeout tick; used only with ALINK_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- txfifo_pop  out  1  one-cycle FIFO read strobe
- txfifo_dout  in  32  FIFO read data, valid the cycle after txfifo_pop
- txcnt  in  11  FIFO word count
- reg_flush  in  1  flush request from slave
- reg_scan  in  1  dispatch enable
- reg_mask  in  32  per-channel enable
- done  in  32  per-channel result-received pulse from RX side
- busy  out  32  per-channel task outstanding
- timeout  out  32  per-channel timeout pulse
- phy_valid  out  1  word valid to PHY
- phy_data  out  32  word to PHY
- phy_chan  out  5  target channel
- phy_last  out  1  last word of frame
- phy_abort  out  1  one-cycle frame abort
- phy_ready  in  1  PHY accepts word

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; last_ch = 31; word_cnt = 0.
- Eligibility: channel i is eligible when reg_mask[i] & ~busy[i].
- FSM states: IDLE, PICK, POP, LOAD, SEND.
- IDLE -> PICK when all hold: reg_scan=1, reg_flush=0, txcnt >= TASK_WORDS, and at least one eligible channel.
- PICK (1 cycle):
  - Latch ch = first eligible index searching upward from last_ch+1, wrapping from 31 to 0.
  - Set last_ch = ch and phy_chan = ch; clear word_cnt.
  - If eligibility vanished this cycle, return to IDLE.
- POP (1 cycle): txfifo_pop=1.
- LOAD (1 cycle): phy_data <= txfifo_dout.
- SEND: phy_valid=1; phy_last=1 when word_cnt == TASK_WORDS-1. phy_data, phy_chan and phy_last stay stable until phy_ready.
  - On a valid&ready word that is not last: word_cnt++ and go to POP.
  - On a valid&ready word that is last: busy[ch] is set next cycle and the FSM goes to IDLE.
- Throughput: minimum 3 cycles per word; exactly one pop per word sent.
- reg_flush=1 in PICK/POP/LOAD/SEND: go to IDLE next cycle.
  - phy_valid drops; phy_abort pulses for 1 cycle if any word of the frame was already accepted or is presented.
  - busy is not set; word_cnt is cleared.
- reg_scan falling mid-frame: the frame completes; no new frame starts.
- busy[i] clears on done[i]=1 or reg_mask[i]=0. When a set and a clear hit the same bit in the same cycle, the set wins.
- done[i] while busy[i]=0 is ignored.
- reg_mask[ch] dropping mid-frame: the frame completes and busy[ch] is set; the mask clear takes effect the following cycle.
- Mid-operation rst: everything returns to reset values immediately. The PHY must treat rst as an abort.

Optional Feature:
- ALINK_TIMEOUT_EN defined:
  - Prescaler counts 0..TICK_CYCLES-1 and emits a tick on wrap.
  - Each channel has a 2-bit age counter: cleared when busy[i] is set; incremented on tick while busy[i]=1.
  - On a tick with age==3: busy[i] clears and timeout[i] pulses for 1 cycle. Timeout therefore falls between 3 and 4 ticks after dispatch.
  - done[i] or reg_mask[i]=0 clears age[i].
- Not defined: no prescaler and no age logic; timeout tied to 0; busy clears only on done or mask.

Test Plan:
- Dispatch: mask=0x00000005, scan=1, 23 words in FIFO, ready=1 -> 23 pops; frame on phy_chan=0; phy_last on word 23; busy=0x00000001.
- Round-robin: mask=0x00000005, 46 words preloaded, no done -> frame 1 goes to ch 0, frame 2 to ch 2; busy=0x00000005; nothing more dispatches until done[0] -> busy=0x00000004.
- Backpressure: phy_ready low for 10 cycles on word 5 -> phy_data and phy_chan stable; no extra pop; word order matches FIFO order.
- Flush mid-frame: reg_flush pulses after word 7 accepted -> phy_abort=1 for 1 cycle; busy unchanged; FSM back in IDLE.
- Gating:
  - txcnt=22 -> no pop.
  - scan=0 -> no pop.
  - All enabled channels busy -> no pop.
  - Same-cycle done and set on one bit -> busy bit stays 1.
- ALINK_TIMEOUT_EN, TICK_CYCLES=8: dispatch to ch 3 with no done -> busy[3] clears and timeout[3] pulses between 24 and 32 cycles after busy set.
